// File: rtl/a1000.sv
// A1000 root clock-phase and reset controller: divides the master clock into the
// four bus phases, stretches/accepts system reset on open-drain _RST, syncs _OVR.
module a1000 #(
    parameter int RST_STRETCH = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic VCC_5V,
    input  logic GND,
    output logic _C1,
    output logic _C3,
    output logic C7M,
    output logic CDAC,
    inout  wire  _RST,
    input  logic _OVR,
    output logic SYS_RST,
    output logic OVR_ACT
);

    localparam logic [15:0] STRETCH = 16'(RST_STRETCH);

    typedef struct packed {
        logic c1;
        logic c3;
        logic c7m;
        logic cdac;
    } phases_t;

    // Bad supply rails behave exactly like a held reset.
    logic rst_eff;
    assign rst_eff = reset | ~(VCC_5V & ~GND);

    function automatic phases_t decode(input logic [2:0] p);
        phases_t d;
        d.c1   = ~p[2];
        d.c3   = (p >= 3'd2) && (p <= 3'd5);
        d.c7m  = ~p[1];
        d.cdac = p[1] ^ p[0];
        return d;
    endfunction

    logic    [2:0] ph;
    logic    [2:0] ph_next;
    phases_t       ph_out;

    assign ph_next = rst_eff ? 3'd7 : ph + 3'd1;
    assign ph_out  = decode(ph_next);

    // Outputs load the decode of the next phase, so they are glitch-free flops
    // that line up with ph itself; decode(7) = 0 makes reset clear them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        ph   <= ph_next;
        _C1  <= ph_out.c1;
        _C3  <= ph_out.c3;
        C7M  <= ph_out.c7m;
        CDAC <= ph_out.cdac;
    end

    logic [15:0] cnt;
    logic        drive;
    logic [1:0]  blank;
    logic [1:0]  rst_s;

    always_ff @(posedge clk) begin
        if (rst_eff) begin
            rst_s <= 2'b11;
        end else begin
            rst_s <= {rst_s[0], _RST};
        end
    end

    // blank masks the two-cycle synchronizer echo of our own released drive.
    always_ff @(posedge clk) begin
        if (rst_eff) begin
            cnt   <= STRETCH;
            drive <= 1'b1;
            blank <= 2'd0;
        end else if (drive) begin
            if (cnt <= 16'd1) begin
                cnt   <= 16'd0;
                drive <= 1'b0;
                blank <= 2'd3;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end else if (blank != 2'd0) begin
            blank <= blank - 2'd1;
        end else if (rst_s[1] == 1'b0) begin
            cnt   <= STRETCH;
            drive <= 1'b1;
        end
    end

    assign SYS_RST = drive;
    assign _RST    = drive ? 1'b0 : 1'bz;

    logic [1:0] ovr_s;

    always_ff @(posedge clk) begin
        if (rst_eff) begin
            ovr_s <= 2'b11;
        end else begin
            ovr_s <= {ovr_s[0], _OVR};
        end
    end

    assign OVR_ACT = ~ovr_s[1];

endmodule

// File: tb/tb_a1000.sv
// Directed bench for a1000: phase sequence, reset stretch, external/blanked
// pulls, supply loss, override sync, and a zero-stretch instance.
module tb_a1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vcc = 1'b1;
    logic gnd = 1'b0;
    logic ovr_n = 1'b1;
    logic ext_pull = 1'b0;

    logic c1, c3, c7m, cdac, sys_rst, ovr_act;
    logic c1_z, c3_z, c7m_z, cdac_z, sys_rst_z, ovr_act_z;
    wire  rst_line;
    wire  rst_line_z;

    pullup (rst_line);
    pullup (rst_line_z);
    assign rst_line = ext_pull ? 1'b0 : 1'bz;

    int checks = 0;
    int fails  = 0;
    logic [2:0] ph_m = 3'd7;

    always #5 clk = ~clk;

    a1000 #(.RST_STRETCH(128)) dut (
        .clk(clk), .reset(reset), .VCC_5V(vcc), .GND(gnd),
        ._C1(c1), ._C3(c3), .C7M(c7m), .CDAC(cdac),
        ._RST(rst_line), ._OVR(ovr_n), .SYS_RST(sys_rst), .OVR_ACT(ovr_act)
    );

    a1000 #(.RST_STRETCH(0)) dut_z (
        .clk(clk), .reset(reset), .VCC_5V(vcc), .GND(gnd),
        ._C1(c1_z), ._C3(c3_z), .C7M(c7m_z), .CDAC(cdac_z),
        ._RST(rst_line_z), ._OVR(ovr_n), .SYS_RST(sys_rst_z), .OVR_ACT(ovr_act_z)
    );

    // (_C1,_C3,C7M,CDAC) for phase 0..7
    function automatic logic [3:0] exp_phase(input logic [2:0] p);
        case (p)
            3'd0: return 4'b1010;
            3'd1: return 4'b1011;
            3'd2: return 4'b1101;
            3'd3: return 4'b1100;
            3'd4: return 4'b0110;
            3'd5: return 4'b0111;
            3'd6: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        if (reset || !vcc || gnd) ph_m = 3'd7;
        else                      ph_m = ph_m + 3'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ovr_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if ({c1, c3, c7m, cdac} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_clocks: got %b expected 0000", {c1, c3, c7m, cdac});
            end
            checks++;
            if (sys_rst !== 1'b1 || sys_rst_z !== 1'b1) begin
                fails++;
                $display("FAIL reset_sys_rst: got %b/%b expected 1/1", sys_rst, sys_rst_z);
            end
            checks++;
            if (rst_line !== 1'b0) begin
                fails++;
                $display("FAIL reset_rst_line: got %b expected 0", rst_line);
            end
            checks++;
            if (ovr_act !== 1'b0) begin
                fails++;
                $display("FAIL reset_ovr_act: got %b expected 0", ovr_act);
            end
        end
        ovr_n = 1'b1;
    endtask

    task automatic test_startup();
        int rises = 0;
        logic c1_prev = 1'b0;
        reset = 1'b0;
        for (int k = 1; k <= 8000; k++) begin
            tick();
            checks++;
            if ({c1, c3, c7m, cdac} !== exp_phase(ph_m)) begin
                fails++;
                $display("FAIL startup_phase edge %0d: got %b expected %b", k, {c1, c3, c7m, cdac}, exp_phase(ph_m));
            end
            if (k <= 130) begin
                checks++;
                if (sys_rst !== (k < 128)) begin
                    fails++;
                    $display("FAIL startup_sys_rst edge %0d: got %b expected %b", k, sys_rst, (k < 128));
                end
                checks++;
                if (rst_line !== (k >= 128)) begin
                    fails++;
                    $display("FAIL startup_rst_line edge %0d: got %b expected %b", k, rst_line, (k >= 128));
                end
            end
            if (k == 1) begin
                checks++;
                if (sys_rst_z !== 1'b0 || rst_line_z !== 1'b1) begin
                    fails++;
                    $display("FAIL zero_stretch: got sys=%b line=%b expected sys=0 line=1", sys_rst_z, rst_line_z);
                end
            end
            if (c1 && !c1_prev) rises++;
            c1_prev = c1;
        end
        checks++;
        if (rises != 1000) begin
            fails++;
            $display("FAIL c1_rise_count: got %0d expected 1000", rises);
        end
    endtask

    // 1-clk external pull, ends on the edge where the stretch releases.
    task automatic test_ext_reset();
        ext_pull = 1'b1;
        for (int k = 1; k <= 131; k++) begin
            tick();
            if (k == 1) ext_pull = 1'b0;
            checks++;
            if (sys_rst !== (k >= 3 && k < 131)) begin
                fails++;
                $display("FAIL ext_sys_rst edge %0d: got %b expected %b", k, sys_rst, (k >= 3 && k < 131));
            end
            if (k >= 3) begin
                checks++;
                if (rst_line !== (k >= 131)) begin
                    fails++;
                    $display("FAIL ext_rst_line edge %0d: got %b expected %b", k, rst_line, (k >= 131));
                end
            end
            checks++;
            if ({c1, c3, c7m, cdac} !== exp_phase(ph_m)) begin
                fails++;
                $display("FAIL ext_phase edge %0d: got %b expected %b", k, {c1, c3, c7m, cdac}, exp_phase(ph_m));
            end
        end
    endtask

    // Pull right after self-release falls inside blank and must be ignored.
    task automatic test_blank_ignore();
        ext_pull = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ext_pull = 1'b0;
            checks++;
            if (sys_rst !== 1'b0) begin
                fails++;
                $display("FAIL blank_ignore edge %0d: got %b expected 0", k, sys_rst);
            end
        end
    endtask

    // Pull held past the blank window is honoured on edge 4 after release.
    task automatic test_blank_honour();
        ext_pull = 1'b1;
        for (int k = 1; k <= 138; k++) begin
            tick();
            if (k == 5) ext_pull = 1'b0;
            checks++;
            if (sys_rst !== (k >= 4 && k < 132)) begin
                fails++;
                $display("FAIL blank_honour edge %0d: got %b expected %b", k, sys_rst, (k >= 4 && k < 132));
            end
            if (k >= 6) begin
                checks++;
                if (rst_line !== (k >= 132)) begin
                    fails++;
                    $display("FAIL honour_rst_line edge %0d: got %b expected %b", k, rst_line, (k >= 132));
                end
            end
        end
    endtask

    task automatic test_power();
        vcc = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({c1, c3, c7m, cdac, sys_rst, rst_line} !== 6'b000010) begin
                fails++;
                $display("FAIL vcc_loss edge %0d: got %b expected 000010", k, {c1, c3, c7m, cdac, sys_rst, rst_line});
            end
        end
        vcc = 1'b1;
        for (int k = 1; k <= 129; k++) begin
            tick();
            checks++;
            if ({c1, c3, c7m, cdac} !== exp_phase(ph_m) || (k == 1 && ph_m !== 3'd0)) begin
                fails++;
                $display("FAIL vcc_restore_phase edge %0d: got %b expected %b", k, {c1, c3, c7m, cdac}, exp_phase(ph_m));
            end
            checks++;
            if (sys_rst !== (k < 128)) begin
                fails++;
                $display("FAIL vcc_restore_sys_rst edge %0d: got %b expected %b", k, sys_rst, (k < 128));
            end
        end
        gnd = 1'b1;
        tick();
        checks++;
        if ({c1, c3, c7m, cdac, sys_rst} !== 5'b00001) begin
            fails++;
            $display("FAIL gnd_fault: got %b expected 00001", {c1, c3, c7m, cdac, sys_rst});
        end
        gnd = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            tick();
            checks++;
            if (sys_rst !== (k < 128)) begin
                fails++;
                $display("FAIL gnd_restore_sys_rst edge %0d: got %b expected %b", k, sys_rst, (k < 128));
            end
        end
    endtask

    task automatic test_reset_restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            tick();
            checks++;
            if (sys_rst !== (k < 128)) begin
                fails++;
                $display("FAIL restart_sys_rst edge %0d: got %b expected %b", k, sys_rst, (k < 128));
            end
        end
    endtask

    task automatic test_override();
        ovr_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) ovr_n = 1'b1;
            checks++;
            if (ovr_act !== (k >= 2 && k <= 6)) begin
                fails++;
                $display("FAIL ovr_act edge %0d: got %b expected %b", k, ovr_act, (k >= 2 && k <= 6));
            end
            checks++;
            if ({c1, c3, c7m, cdac} !== exp_phase(ph_m)) begin
                fails++;
                $display("FAIL ovr_phase edge %0d: got %b expected %b", k, {c1, c3, c7m, cdac}, exp_phase(ph_m));
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_ext_reset();
        test_blank_ignore();
        test_ext_reset();
        test_blank_honour();
        test_power();
        test_reset_restart();
        test_override();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
